// File: rtl/wrong_guess_tracker_pkg.sv
// Shared constants for the hangman game-state tracker: state encoding,
// default game limits and the letter code width.
package hangman_pkg;

  localparam int LETTER_W      = 5;
  localparam int MAX_WRONG_DEF = 6;
  localparam int ALPHA_DEF     = 26;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PLAY = 2'd1;
  localparam state_t ST_WON  = 2'd2;
  localparam state_t ST_LOST = 2'd3;

endpackage

// File: rtl/wrong_guess_tracker_guess_mask.sv
// Register of already-guessed letters: synchronous clear, set-by-index,
// and a combinational lookup of the bit selected by idx.
module guess_mask
  import hangman_pkg::*;
#(
  parameter int W = ALPHA_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clr,
  input  logic                set,
  input  logic [LETTER_W-1:0] idx,
  output logic [W-1:0]        mask,
  output logic                seen
);

  logic [W-1:0] mask_q;
  logic [W-1:0] mask_d;

  // Next mask: clear wins over set; out-of-range indices never touch the mask.
  always_comb begin
    mask_d = mask_q;
    if (clr) begin
      mask_d = '0;
    end else if (set && (32'(idx) < W)) begin
      mask_d[idx] = 1'b1;
    end
  end

  // Mask storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  // Lookup of the indexed letter; out-of-range letters read as unseen.
  always_comb begin
    seen = 1'b0;
    if (32'(idx) < W) begin
      seen = mask_q[idx];
    end
  end

  assign mask = mask_q;

endmodule

// File: rtl/wrong_guess_tracker.sv
// Hangman game-state tracker: filters guesses (range, repeat), counts
// misses with saturation at MAX_WRONG, and declares win or loss.
//
// Handshake: guess_valid is a single-cycle strobe qualifying letter and
// guess_hit in the same cycle. There is no ready; every strobe is consumed
// on the edge it is presented, so back-to-back strobes are all accepted.
// In IDLE, WON and LOST strobes are silently dropped.
module wrong_guess_tracker
  import hangman_pkg::*;
#(
  parameter int MAX_WRONG = MAX_WRONG_DEF,
  parameter int ALPHA     = ALPHA_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                new_game,
  input  logic                guess_valid,
  input  logic [LETTER_W-1:0] letter,
  input  logic                guess_hit,
  input  logic                word_done,
  output logic [2:0]          wrong_cnt,
  output logic                lose,
  output logic                win,
  output logic                dup,
  output logic                bad_letter,
  output logic [ALPHA-1:0]    guessed,
  output state_t              dbg_state
);

  state_t     state_q, state_d;
  logic [2:0] wrong_cnt_q, wrong_cnt_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;
  logic       dup_q, dup_d;
  logic       bad_letter_q, bad_letter_d;
  logic       mask_clr, mask_set, seen;
  logic       miss;

  guess_mask #(.W(ALPHA)) u_mask (
    .clk    (clk),
    .resetn (resetn),
    .clr    (mask_clr),
    .set    (mask_set),
    .idx    (letter),
    .mask   (guessed),
    .seen   (seen)
  );

  // Game FSM, guess filtering and saturating miss counter.
  always_comb begin
    state_d      = state_q;
    wrong_cnt_d  = wrong_cnt_q;
    win_d        = win_q;
    lose_d       = lose_q;
    dup_d        = 1'b0;
    bad_letter_d = 1'b0;
    mask_clr     = 1'b0;
    mask_set     = 1'b0;
    miss         = 1'b0;

    if (new_game) begin
      // A restart drops any coincident guess.
      state_d     = ST_PLAY;
      wrong_cnt_d = 3'd0;
      win_d       = 1'b0;
      lose_d      = 1'b0;
      mask_clr    = 1'b1;
    end else if (state_q == ST_PLAY) begin
      if (guess_valid) begin
        if (32'(letter) >= ALPHA) begin
          bad_letter_d = 1'b1;
        end else if (seen) begin
          dup_d = 1'b1;
        end else begin
          mask_set = 1'b1;
          if (!guess_hit && (32'(wrong_cnt_q) < MAX_WRONG)) begin
            miss        = 1'b1;
            wrong_cnt_d = 3'(wrong_cnt_q + 3'd1);
          end
        end
      end
      // A completed word beats a final miss landing on the same edge.
      if (word_done) begin
        state_d = ST_WON;
        win_d   = 1'b1;
      end else if (miss && (32'(wrong_cnt_d) == MAX_WRONG)) begin
        state_d = ST_LOST;
        lose_d  = 1'b1;
      end
    end
  end

  // State, counter and pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      wrong_cnt_q  <= 3'd0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      dup_q        <= 1'b0;
      bad_letter_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrong_cnt_q  <= wrong_cnt_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
      dup_q        <= dup_d;
      bad_letter_q <= bad_letter_d;
    end
  end

  assign wrong_cnt  = wrong_cnt_q;
  assign win        = win_q;
  assign lose       = lose_q;
  assign dup        = dup_q;
  assign bad_letter = bad_letter_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/wrong_guess_tracker.md
# wrong_guess_tracker

Game-state tracker for the hangman datapath: accepts one letter guess at a time and the hit/miss verdict from the word matcher. Rejects repeated and out-of-range letters, counts misses, and declares win or loss. Its `wrong_cnt` output is the 3-bit miss count consumed by the LED lose-display decoder, which expects values 0..6. It sits between the keyboard/switch guess input and the display decoders.

## Interface
- `MAX_WRONG`, default 6: number of misses that ends the game; must be ≤ 7.
- `ALPHA`, default 26: alphabet size; valid letter codes are 0..ALPHA-1.
- `clk` in 1: system clock, all state changes on the rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `new_game` in 1: single-cycle pulse that starts or restarts a game.
- `guess_valid` in 1: single-cycle strobe; `letter` and `guess_hit` are valid this cycle.
- `letter` in 5: guessed letter code.
- `guess_hit` in 1: 1 when the matcher found `letter` in the secret word.
- `word_done` in 1: level from the matcher; 1 when every letter of the word is revealed.
- `wrong_cnt` out 3: registered miss count, 0..MAX_WRONG, drives the lose display.
- `lose` out 1: registered; 1 while in LOST.
- `win` out 1: registered; 1 while in WON.
- `dup` out 1: one-cycle pulse when a guess is rejected as a repeat.
- `bad_letter` out 1: one-cycle pulse when `letter` ≥ ALPHA.
- `guessed` out ALPHA: registered mask of letters already guessed.

## Operation
- States: IDLE, PLAY, WON, LOST. The encoding lives in the package.
- IDLE: guesses are ignored and produce no pulses. `new_game` moves to PLAY.
- PLAY, on `guess_valid`, checks are applied in this priority order:
  1. If `letter` ≥ ALPHA: pulse `bad_letter`; no other change.
  2. Else if `guessed[letter]` is 1: pulse `dup`; the count is unchanged and the guess is not a miss.
  3. Else set `guessed[letter]`. If `guess_hit` = 0, increment `wrong_cnt`.
- Transitions out of PLAY:
  - To LOST when the increment makes `wrong_cnt` equal MAX_WRONG.
  - To WON when `word_done` = 1, sampled any PLAY cycle.
  - If both occur in the same cycle, WON wins, and `wrong_cnt` still takes the incremented value.
- WON and LOST hold all outputs. Guesses are ignored with no `dup`/`bad_letter` pulses. `new_game` moves to PLAY.
- `new_game` in any state clears `wrong_cnt`, `guessed`, `win` and `lose`, then enters PLAY. When it coincides with `guess_valid`, `new_game` has priority and the guess is dropped.
- `wrong_cnt` never exceeds MAX_WRONG and never wraps.

## Timing
- Reset values:
  - state IDLE
  - `wrong_cnt` = 0
  - `guessed` = 0
  - `win` = 0, `lose` = 0, `dup` = 0, `bad_letter` = 0
- Latency: one cycle. A guess strobed at edge N shows `wrong_cnt`, `guessed`, `dup`, `bad_letter`, `win` and `lose` updated after edge N+1.
- `dup` and `bad_letter` are high for exactly one cycle per offending strobe.
- Back-to-back strobes on consecutive cycles are all accepted; there is no busy/stall.
- `resetn` asserted mid-game forces reset values immediately, independent of `clk`.
- `word_done` is sampled only in PLAY and only on clock edges.

## Structure
- Package `hangman_pkg`:
  - state typedef/localparams (IDLE, PLAY, WON, LOST)
  - `MAX_WRONG` and `ALPHA` defaults
  - letter width constant (5)
- Sub-module `guess_mask`:
  - ALPHA-bit register with synchronous clear and set-by-index, sharing the same `clk`/`resetn`
  - combinational `seen` output for the indexed bit
- Top level contains the FSM, the saturating counter and the pulse registers.

## Test plan
- Reset, then `new_game`; six distinct misses (letters 0..5, `guess_hit`=0) → `wrong_cnt` steps 1..6, `lose`=1 one cycle after the 6th guess, `win`=0.
- In PLAY, letter 7 miss, then letter 7 again → `wrong_cnt`=1 after the first guess; the second guess pulses `dup` for one cycle and `wrong_cnt` stays 1.
- Letter 30 with `guess_valid` → `bad_letter` pulses, `wrong_cnt` and `guessed` unchanged.
- `wrong_cnt`=5, then a miss arriving with `word_done`=1 in the same cycle → `win`=1, `lose`=0, `wrong_cnt`=6.
- In LOST, strobe guesses → no pulses, no change. Then `new_game` together with `guess_valid` → PLAY, `wrong_cnt`=0, `guessed`=0, guess dropped.
- `resetn` low mid-game with `wrong_cnt`=3 → `wrong_cnt`=0 and state IDLE without a clock edge. Guesses after deassertion are ignored until `new_game`.
